// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: 8N1 UART receiver feeding command bytes to the parser.
// 16x oversampling, majority vote, framing-error recovery via idle wait.
module uart_cmd_rx #(
    parameter int BASE_DIV   = 54,
    parameter int IDLE_TICKS = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic [3:0] baud_rate,
    output logic [7:0] cmd,
    output logic       cmd_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int PW = (BASE_DIV > 1) ? $clog2(BASE_DIV) : 1;
    localparam int IW = $clog2(IDLE_TICKS + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t        state_q, state_d;
    logic          rx_q1, rx_s, rx_d;
    logic [3:0]    rate_q;
    logic [PW-1:0] presc_q;
    logic [3:0]    cnt_q;
    logic [2:0]    bit_q;
    logic          s7_q, s8_q;
    logic [7:0]    sh_q;
    logic [IW-1:0] idle_q;
    logic [7:0]    cmd_q;
    logic          valid_q, ferr_q;

    logic tick, maj, fall;
    logic load, err, shift_en;

    function automatic logic [PW-1:0] reload(input logic [3:0] r);
        int d;
        d = BASE_DIV >> r;
        if (d < 1) d = 1;
        return PW'(d - 1);
    endfunction

    assign tick = (state_q != IDLE) && (presc_q == '0);
    assign maj  = (s7_q & s8_q) | (s7_q & rx_s) | (s8_q & rx_s);
    assign fall = rx_d & ~rx_s;

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        err      = 1'b0;
        shift_en = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (fall) state_d = START;
            end
            START: begin
                if (tick && cnt_q == 4'd9 && maj)
                    state_d = IDLE;
                else if (tick && cnt_q == 4'd15)
                    state_d = DATA;
            end
            DATA: begin
                if (tick && cnt_q == 4'd9) shift_en = 1'b1;
                if (tick && cnt_q == 4'd15 && bit_q == 3'd7)
                    state_d = STOP;
            end
            STOP: begin
                // Decide early to leave margin for the next start edge
                if (tick && cnt_q == 4'd9) begin
                    if (maj) begin
                        load    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        err     = 1'b1;
                        state_d = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (tick && rx_s && idle_q == IW'(IDLE_TICKS - 1))
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rx_q1   <= 1'b1;
            rx_s    <= 1'b1;
            rx_d    <= 1'b1;
            rate_q  <= '0;
            presc_q <= '0;
            cnt_q   <= '0;
            bit_q   <= '0;
            s7_q    <= 1'b0;
            s8_q    <= 1'b0;
            sh_q    <= '0;
            idle_q  <= '0;
            cmd_q   <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rx_q1   <= rx;
            rx_s    <= rx_q1;
            rx_d    <= rx_s;
            valid_q <= load;
            ferr_q  <= err;
            if (state_q == IDLE) begin
                rate_q  <= baud_rate;
                presc_q <= reload(baud_rate);
                cnt_q   <= '0;
            end else begin
                presc_q <= tick ? reload(rate_q) : presc_q - 1'b1;
                if (tick) cnt_q <= cnt_q + 1'b1;
            end
            if (tick && cnt_q == 4'd7) s7_q <= rx_s;
            if (tick && cnt_q == 4'd8) s8_q <= rx_s;
            if (state_q != DATA)
                bit_q <= '0;
            else if (tick && cnt_q == 4'd15)
                bit_q <= bit_q + 1'b1;
            if (shift_en) sh_q <= {maj, sh_q[7:1]};
            if (state_q != WAIT_IDLE)
                idle_q <= '0;
            else if (tick)
                idle_q <= rx_s ? idle_q + 1'b1 : '0;
            if (load) cmd_q <= sh_q;
        end
    end

    assign cmd       = cmd_q;
    assign cmd_valid = valid_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_cmd_rx.sv
// tb_uart_cmd_rx: directed bench for uart_cmd_rx at BASE_DIV=4.
// Frames are driven bit by bit; a negedge monitor records pulses.
module tb_uart_cmd_rx;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [3:0] baud_rate;
    logic [7:0] cmd;
    logic       cmd_valid;
    logic       frame_err;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int nvalid = 0;
    int nerr = 0;
    int overlap = 0;
    int badchg = 0;
    int vcyc[$];
    logic [7:0] vcmd[$];
    logic prev_any = 1'b0;
    logic [7:0] prev_cmd = 8'h00;

    uart_cmd_rx #(.BASE_DIV(4), .IDLE_TICKS(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .baud_rate (baud_rate),
        .cmd       (cmd),
        .cmd_valid (cmd_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cmd_valid) begin
            nvalid = nvalid + 1;
            vcyc.push_back(cyc);
            vcmd.push_back(cmd);
        end
        if (frame_err) nerr = nerr + 1;
        if ((cmd_valid && frame_err) ||
            ((cmd_valid || frame_err) && prev_any))
            overlap = overlap + 1;
        prev_any = cmd_valid | frame_err;
        if (rst_n && !cmd_valid && cmd !== prev_cmd)
            badchg = badchg + 1;
        prev_cmd = cmd;
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b,
                              input int cpb,
                              input logic stp);
        logic [9:0] f;
        f = {stp, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = f[i];
            wait_cyc(cpb);
        end
        rx = 1'b1;
    endtask

    int t0, n0, e0;

    initial begin
        rst_n     = 1'b0;
        rx        = 1'b1;
        baud_rate = 4'd0;
        wait_cyc(3);
        check("rst_cmd", {24'h0, cmd}, 32'h00);
        check("rst_valid", {31'h0, cmd_valid}, 0);
        check("rst_ferr", {31'h0, frame_err}, 0);
        check("rst_busy", {31'h0, busy}, 0);
        rst_n = 1'b1;
        wait_cyc(10);

        // single byte at 64 clk/bit
        n0 = nvalid;
        t0 = cyc;
        send_frame(8'hA1, 64, 1'b1);
        wait_cyc(50);
        check("single_cnt", nvalid - n0, 1);
        check("single_cmd", {24'h0, cmd}, 32'hA1);
        check("single_lat_ok",
              ((vcyc[n0] - t0) >= 618 && (vcyc[n0] - t0) <= 620), 1);
        check("single_ferr", nerr, 0);
        check("single_busy", {31'h0, busy}, 0);

        // glitch reject
        n0 = nvalid;
        rx = 1'b0;
        wait_cyc(10);
        check("glitch_busy_hi", {31'h0, busy}, 1);
        wait_cyc(10);
        rx = 1'b1;
        wait_cyc(100);
        check("glitch_cnt", nvalid - n0, 0);
        check("glitch_ferr", nerr, 0);
        check("glitch_cmd", {24'h0, cmd}, 32'hA1);
        check("glitch_busy_lo", {31'h0, busy}, 0);

        // framing error, long break, recovery
        n0 = nvalid;
        e0 = nerr;
        send_frame(8'h3C, 64, 1'b0);
        rx = 1'b0;
        wait_cyc(200);
        rx = 1'b1;
        check("ferr_cnt", nerr - e0, 1);
        check("ferr_cmd", {24'h0, cmd}, 32'hA1);
        check("ferr_novalid", nvalid - n0, 0);
        wait_cyc(40);
        check("ferr_wait_busy", {31'h0, busy}, 1);
        wait_cyc(40);
        check("ferr_idle", {31'h0, busy}, 0);
        check("ferr_novalid2", nvalid - n0, 0);
        send_frame(8'h55, 64, 1'b1);
        wait_cyc(30);
        check("recov_cnt", nvalid - n0, 1);
        check("recov_cmd", {24'h0, cmd}, 32'h55);

        // rate change mid-frame applies to the next frame
        fork
            send_frame(8'h11, 64, 1'b1);
            begin
                wait_cyc(200);
                baud_rate = 4'd2;
            end
        join
        wait_cyc(20);
        check("rate_old_cmd", {24'h0, cmd}, 32'h11);
        n0 = nvalid;
        t0 = cyc;
        send_frame(8'hD4, 16, 1'b1);
        wait_cyc(20);
        check("rate_new_cmd", {24'h0, cmd}, 32'hD4);
        check("rate_new_lat_ok",
              ((vcyc[n0] - t0) >= 156 && (vcyc[n0] - t0) <= 158), 1);
        baud_rate = 4'd3;
        wait_cyc(5);
        send_frame(8'h6B, 16, 1'b1);
        wait_cyc(20);
        check("rate_sat_cmd", {24'h0, cmd}, 32'h6B);

        // back-to-back frames, no idle gap
        baud_rate = 4'd0;
        wait_cyc(5);
        n0 = nvalid;
        send_frame(8'h01, 64, 1'b1);
        send_frame(8'h4D, 64, 1'b1);
        send_frame(8'hFF, 64, 1'b1);
        wait_cyc(50);
        check("b2b_cnt", nvalid - n0, 3);
        if (nvalid - n0 == 3) begin
            check("b2b_cmd0", {24'h0, vcmd[n0]}, 32'h01);
            check("b2b_cmd1", {24'h0, vcmd[n0+1]}, 32'h4D);
            check("b2b_cmd2", {24'h0, vcmd[n0+2]}, 32'hFF);
            check("b2b_gap1", vcyc[n0+1] - vcyc[n0], 640);
            check("b2b_gap2", vcyc[n0+2] - vcyc[n0+1], 640);
        end

        // reset during bit 4 of 0xF0
        n0 = nvalid;
        e0 = nerr;
        fork
            send_frame(8'hF0, 64, 1'b1);
            begin
                wait_cyc(352);
                check("mid_busy", {31'h0, busy}, 1);
                rst_n = 1'b0;
                #2;
                check("mid_rst_cmd", {24'h0, cmd}, 32'h00);
                check("mid_rst_busy", {31'h0, busy}, 0);
                check("mid_rst_valid", {31'h0, cmd_valid}, 0);
                wait_cyc(5);
                rst_n = 1'b1;
            end
        join
        wait_cyc(50);
        check("mid_nopulse", nvalid - n0, 0);
        check("mid_noerr", nerr - e0, 0);
        check("mid_cmd", {24'h0, cmd}, 32'h00);
        send_frame(8'h92, 64, 1'b1);
        wait_cyc(30);
        check("after_rst_cnt", nvalid - n0, 1);
        check("after_rst_cmd", {24'h0, cmd}, 32'h92);

        check("pulse_exclusive", overlap, 0);
        check("cmd_stable", badchg, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
